// File: rtl/commit_free_list.sv
// commit_free_list: retirement alias table plus circular physical-register
// free list. Commits return displaced registers to the ring tail; rename
// allocates from the head; a flush rewinds head to the oldest in-flight
// allocation so every speculative register becomes free again in one cycle.
module commit_free_list #(
    parameter  int NUM_PHYS_REGS = 64,
    parameter  int NUM_ARCH_REGS = 32,
    parameter  int DEPTH         = NUM_PHYS_REGS - NUM_ARCH_REGS,
    localparam int PW            = $clog2(NUM_PHYS_REGS),
    localparam int AW            = $clog2(NUM_ARCH_REGS),
    localparam int DW            = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          alloc_req,
    output logic [PW-1:0] free_preg,
    output logic          free_empty,
    output logic [DW:0]   free_count,
    input  logic          commit_valid,
    input  logic [AW-1:0] commit_arch,
    input  logic [PW-1:0] commit_preg,
    input  logic          FLUSH_IN,
    input  logic [AW-1:0] rrat_rd_arch,
    output logic [PW-1:0] rrat_rd_preg,
    output logic          protocol_err
);

    logic [PW-1:0] ring [DEPTH];
    logic [PW-1:0] rrat [NUM_ARCH_REGS];
    logic [DW-1:0] head, tail, retire_head;
    logic [DW:0]   free_cnt, inflight;

    logic          alloc_ok, commit_ok, alloc_err, commit_err;
    logic [PW-1:0] push_preg;

    // Ring pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [DW-1:0] ptr_inc(input logic [DW-1:0] p);
        return (p == DW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Grant/commit qualification against registered state only (no bypass).
    always_comb begin
        alloc_ok   = alloc_req && !FLUSH_IN && (free_cnt != '0);
        alloc_err  = alloc_req && !FLUSH_IN && (free_cnt == '0);
        commit_ok  = commit_valid && (inflight != '0);
        commit_err = commit_valid && (inflight == '0);
        // arch 0 never remaps: the committing register itself goes back.
        push_preg  = (commit_arch != '0) ? rrat[commit_arch] : commit_preg;
    end

    // Ring contents and RRAT: identity map and fresh registers after reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int k = 0; k < DEPTH; k++)
                ring[k] <= PW'(NUM_ARCH_REGS + k);
            for (int i = 0; i < NUM_ARCH_REGS; i++)
                rrat[i] <= PW'(i);
        end else if (commit_ok) begin
            ring[tail] <= push_preg;
            if (commit_arch != '0)
                rrat[commit_arch] <= commit_preg;
        end
    end

    // Pointers and counters; a flush folds in-flight back into free.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            head         <= '0;
            tail         <= '0;
            retire_head  <= '0;
            free_cnt     <= (DW+1)'(DEPTH);
            inflight     <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (commit_ok) begin
                tail        <= ptr_inc(tail);
                retire_head <= ptr_inc(retire_head);
            end
            if (FLUSH_IN) begin
                // Rewind to the post-commit retire point; commit nets to zero.
                head     <= commit_ok ? ptr_inc(retire_head) : retire_head;
                free_cnt <= free_cnt + inflight;
                inflight <= '0;
            end else begin
                if (alloc_ok)
                    head <= ptr_inc(head);
                free_cnt <= free_cnt + (DW+1)'(commit_ok) - (DW+1)'(alloc_ok);
                inflight <= inflight + (DW+1)'(alloc_ok) - (DW+1)'(commit_ok);
            end
            if (alloc_err || commit_err)
                protocol_err <= 1'b1;
        end
    end

    assign free_preg    = ring[head];
    assign free_empty   = (free_cnt == '0);
    assign free_count   = free_cnt;
    assign rrat_rd_preg = rrat[rrat_rd_arch];

endmodule

// File: tb/tb_commit_free_list.sv
// tb_commit_free_list: directed scenarios pinned with literal values, then a
// randomized run checked every cycle against a queue-based model: a free
// queue, an in-flight queue (oldest first) and an RRAT array.
module tb_commit_free_list;

    localparam int NP = 64;
    localparam int NA = 32;
    localparam int DP = NP - NA;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       alloc_req;
    logic [5:0] free_preg;
    logic       free_empty;
    logic [5:0] free_count;
    logic       commit_valid;
    logic [4:0] commit_arch;
    logic [5:0] commit_preg;
    logic       FLUSH_IN;
    logic [4:0] rrat_rd_arch;
    logic [5:0] rrat_rd_preg;
    logic       protocol_err;

    commit_free_list #(.NUM_PHYS_REGS(NP), .NUM_ARCH_REGS(NA)) dut (
        .CLK(CLK), .RESET(RESET),
        .alloc_req(alloc_req), .free_preg(free_preg),
        .free_empty(free_empty), .free_count(free_count),
        .commit_valid(commit_valid), .commit_arch(commit_arch),
        .commit_preg(commit_preg), .FLUSH_IN(FLUSH_IN),
        .rrat_rd_arch(rrat_rd_arch), .rrat_rd_preg(rrat_rd_preg),
        .protocol_err(protocol_err)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    // Model state
    int fq[$];
    int iq[$];
    int rrat[NA];
    bit err;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        fq.delete();
        iq.delete();
        for (int k = 0; k < DP; k++) fq.push_back(NA + k);
        for (int i = 0; i < NA; i++) rrat[i] = i;
        err = 0;
    endfunction

    // One clock of architectural behaviour, decided on pre-edge state.
    function automatic void model_clock();
        bit a_ok, c_ok;
        int disp;
        a_ok = alloc_req && !FLUSH_IN && fq.size() > 0;
        c_ok = commit_valid && iq.size() > 0;
        if (alloc_req && !FLUSH_IN && fq.size() == 0) err = 1;
        if (commit_valid && iq.size() == 0) err = 1;
        if (c_ok) begin
            disp = (commit_arch != 0) ? rrat[commit_arch] : int'(commit_preg);
            if (commit_arch != 0) rrat[commit_arch] = commit_preg;
            void'(iq.pop_front());
            fq.push_back(disp);
        end
        if (FLUSH_IN) begin
            while (iq.size() > 0) fq.push_front(iq.pop_back());
        end else if (a_ok) begin
            iq.push_back(fq.pop_front());
        end
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("free_count", free_count, fq.size());
            check("free_empty", free_empty, fq.size() == 0);
            if (fq.size() > 0) check("free_preg", free_preg, fq[0]);
            check("protocol_err", protocol_err, err);
            check("rrat_rd_preg", rrat_rd_preg, rrat[rrat_rd_arch]);
        end
    end

    task automatic idle();
        alloc_req = 0; commit_valid = 0; commit_arch = 0;
        commit_preg = 0; FLUSH_IN = 0;
    endtask

    task automatic step();
        @(posedge CLK);
        model_clock();
        #1;
    endtask

    task automatic cyc(input bit a, input bit cv, input int arch, input int preg, input bit fl);
        alloc_req = a; commit_valid = cv; commit_arch = 5'(arch);
        commit_preg = 6'(preg); FLUSH_IN = fl;
        step();
        idle();
    endtask

    task automatic do_reset();
        chk_en = 0;
        idle();
        RESET = 0;
        model_reset();
        @(posedge CLK);
        #2;
        RESET = 1;
        #1;
        chk_en = 1;
    endtask

    initial begin
        RESET = 1;
        rrat_rd_arch = 0;
        idle();
        model_reset();
        #1;
        do_reset();

        // Reset state
        rrat_rd_arch = 5;
        #1;
        check("rst_free_preg", free_preg, 32);
        check("rst_free_count", free_count, 32);
        check("rst_rrat5", rrat_rd_preg, 5);
        check("rst_err", protocol_err, 0);

        // Allocate 3, commit arch 5 -> preg 32
        repeat (3) cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 5, 32, 0);
        rrat_rd_arch = 5;
        #1;
        check("c1_rrat5", rrat_rd_preg, 32);
        check("c1_free_count", free_count, 30);
        check("c1_free_preg", free_preg, 35);

        // Allocate 4, commit + flush together, then allocate through the wrap
        do_reset();
        repeat (4) cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 5, 32, 1);
        check("fl_free_count", free_count, 32);
        check("fl_free_preg", free_preg, 33);
        for (int i = 0; i < 31; i++) begin
            if (i < 3) check("fl_realloc", free_preg, 33 + i);
            cyc(1, 0, 0, 0, 0);
        end
        check("fl_wrap_preg", free_preg, 5);

        // Exhaust the list; alloc + commit in the same cycle is refused
        do_reset();
        repeat (32) cyc(1, 0, 0, 0, 0);
        check("ex_empty", free_empty, 1);
        check("ex_err_pre", protocol_err, 0);
        cyc(1, 1, 0, 32, 0);
        check("ex_err", protocol_err, 1);
        check("ex_free_count", free_count, 1);
        check("ex_free_preg", free_preg, 32);

        // Commit and flush together with inflight=2, free=30
        do_reset();
        repeat (2) cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 7, 33, 1);
        rrat_rd_arch = 7;
        #1;
        check("cf_rrat7", rrat_rd_preg, 33);
        check("cf_free_count", free_count, 32);
        check("cf_free_preg", free_preg, 33);

        // Asynchronous reset mid-stream
        do_reset();
        repeat (10) cyc(1, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) cyc(0, 1, i, 40 + i, 0);
        rrat_rd_arch = 3;
        #1;
        check("mr_pre_rrat3", rrat_rd_preg, 43);
        chk_en = 0;
        RESET = 0;
        model_reset();
        #1;
        check("mr_free_count", free_count, 32);
        check("mr_free_preg", free_preg, 32);
        check("mr_rrat3", rrat_rd_preg, 3);
        check("mr_empty", free_empty, 0);
        @(posedge CLK);
        #2;
        RESET = 1;
        #1;
        chk_en = 1;

        // Randomized traffic; protocol violations kept rare
        for (int c = 0; c < 4000; c++) begin
            alloc_req    = (fq.size() > 0) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 49) == 0);
            commit_valid = (iq.size() > 0) ? ($urandom_range(0, 9) < 5) : ($urandom_range(0, 199) == 0);
            commit_arch  = 5'($urandom_range(0, NA - 1));
            commit_preg  = 6'($urandom_range(0, NP - 1));
            FLUSH_IN     = ($urandom_range(0, 39) == 0);
            rrat_rd_arch = 5'($urandom_range(0, NA - 1));
            step();
        end
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/commit_free_list.md
Name: commit_free_list

Overview:
- Consumes the reorder buffer's in-order commit stream: regWrite, architectural destination and physical destination.
- Maintains the retirement alias table (RRAT), which maps each architectural register to its committed physical register.
- Returns each displaced physical register to a circular free list. The rename stage allocates new destinations from that list.
- On pipeline flush, rewinds the free-list allocation pointer so every speculatively allocated register is free again in one cycle.

Parameters:
- NUM_PHYS_REGS, 64, physical register file size; PW = $clog2(NUM_PHYS_REGS).
- NUM_ARCH_REGS, 32, architectural register count; AW = $clog2(NUM_ARCH_REGS).
- DEPTH, NUM_PHYS_REGS-NUM_ARCH_REGS, free-list ring capacity; DW = $clog2(DEPTH).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- alloc_req  in  1  rename consumes free_preg this cycle.
- free_preg  out  PW  physical register at the free-list head (combinational).
- free_empty  out  1  no free register available (registered count == 0).
- free_count  out  DW+1  number of free entries.
- commit_valid  in  1  ROB commits a register-writing instruction.
- commit_arch  in  AW  architectural destination of the committing instruction.
- commit_preg  in  PW  physical destination of the committing instruction.
- FLUSH_IN  in  1  discard all speculative (uncommitted) allocations.
- rrat_rd_arch  in  AW  RRAT read address, used by rename to rebuild its table after a flush.
- rrat_rd_preg  out  PW  RRAT[rrat_rd_arch] (combinational, reflects registered state).
- protocol_err  out  1  sticky error flag.

Behaviour:
- State:
  - ring[DEPTH] of PW bits.
  - Pointers head (allocate), tail (free), retire_head (oldest in-flight allocation), each DW bits, wrapping DEPTH-1 -> 0.
  - Counters free_cnt and inflight, each DW+1 bits.
  - RRAT[NUM_ARCH_REGS].
- Reset (RESET low, asynchronous):
  - RRAT[i]=i.
  - ring[k]=NUM_ARCH_REGS+k.
  - head=retire_head=tail=0; free_cnt=DEPTH; inflight=0; protocol_err=0.
  - Outputs after reset: free_preg=NUM_ARCH_REGS, free_empty=0, free_count=DEPTH.
  - Reset mid-operation discards all state the same way.
- Allocate (no flush):
  - Pop on alloc_req && free_cnt!=0: head++, free_cnt--, inflight++.
  - alloc_req with free_cnt==0: no state change; protocol_err<=1.
- Commit (evaluated every cycle, including flush cycles):
  - Applies when commit_valid && inflight!=0.
  - commit_arch!=0: push RRAT[commit_arch] at ring[tail]; RRAT[commit_arch]<=commit_preg.
  - commit_arch==0: push commit_preg itself; RRAT[0] unchanged (stays the register holding zero).
  - In both cases: tail++, free_cnt++, retire_head++, inflight--.
  - commit_valid with inflight==0: ignored; protocol_err<=1.
- Simultaneous alloc and commit: both apply; free_cnt and inflight net unchanged.
- No bypass: a register pushed this cycle is not allocatable until the next cycle. When free_cnt==0, alloc_req fails even if a commit arrives in the same cycle.
- FLUSH_IN (takes priority over alloc; alloc_req is ignored and not an error):
  - Apply any same-cycle commit first.
  - Then head<=retire_head (post-commit value), free_cnt<=free_cnt+inflight (pre-commit values; the commit's contribution nets to zero), inflight<=0.
  - RRAT reflects the commit in the same cycle.
- Invariants:
  - free_cnt+inflight <= DEPTH.
  - The ring span from retire_head to tail equals free_cnt+inflight.
  - Full ring: free_cnt==DEPTH only when inflight==0. Pushes cannot overflow because each push is paired with a retire_head advance.
- Latency:
  - free_preg and free_empty reflect registered state.
  - RRAT writes are visible on rrat_rd_preg the cycle after commit.
- protocol_err is cleared only by reset.

Test Plan:
- Reset, no activity: free_preg=32, free_count=32, rrat_rd_arch=5 -> rrat_rd_preg=5, protocol_err=0.
- Allocate 3 (regs 32, 33, 34), then commit arch=5/preg=32: RRAT[5]=32, reg 5 pushed at ring[0], free_count=30, next free_preg=35.
- Allocate 4, commit 1, FLUSH_IN: free_count returns to 32 - 0 = 32 and free_preg=33. Allocating again yields 33, 34, 35 in order, and the wrap delivers 5 after ring entry 31.
- Allocate 32 -> free_empty=1. alloc_req plus commit arch=0/preg=32 in the same cycle: alloc not granted, protocol_err=1, next cycle free_count=1, free_preg=32.
- Commit and FLUSH_IN in the same cycle with inflight=2 and free_cnt=30: RRAT updated, free_count=32, head equals the post-commit retire_head.
- Assert RESET mid-stream after 10 allocs and 4 commits: all pointers return to 0, RRAT becomes identity, free_count=32 asynchronously, before the next CLK edge.
